// File: rtl/bk_chunk_addsub.sv
// Multi-cycle wide adder/subtractor: one CHUNK-bit Brent-Kung core reused over
// WIDTH/CHUNK cycles, least-significant chunk first, with a registered carry.
module bk_chunk_addsub #(
   parameter int WIDTH = 256,
   parameter int CHUNK = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_zero
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int LOG2C  = $clog2(CHUNK);
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Brent-Kung prefix adder; carry-in is folded into bit 0's generate so the
   // group generate at bit i-1 is directly the carry into bit i.
   function automatic logic [CHUNK:0] bk_add(input logic [CHUNK-1:0] a,
                                             input logic [CHUNK-1:0] b,
                                             input logic             cin);
      logic [CHUNK-1:0] p;
      logic [CHUNK-1:0] gp;
      logic [CHUNK-1:0] pp;
      logic [CHUNK-1:0] c;
      p     = a ^ b;
      gp    = a & b;
      gp[0] = gp[0] | (p[0] & cin);
      pp    = p;
      for (int l = 0; l < LOG2C; l++) begin
         for (int i = 0; i < CHUNK; i++) begin
            if (((i + 1) % (32'sd1 <<< (l + 1))) == 0) begin
               gp[i] = gp[i] | (pp[i] & gp[i - (32'sd1 <<< l)]);
               pp[i] = pp[i] & pp[i - (32'sd1 <<< l)];
            end
         end
      end
      for (int l = LOG2C - 2; l >= 0; l--) begin
         for (int i = 0; i < CHUNK; i++) begin
            if ((i >= (32'sd1 <<< (l + 1))) &&
                (((i + 1) % (32'sd1 <<< (l + 1))) == (32'sd1 <<< l))) begin
               gp[i] = gp[i] | (pp[i] & gp[i - (32'sd1 <<< l)]);
               pp[i] = pp[i] & pp[i - (32'sd1 <<< l)];
            end
         end
      end
      c[0] = cin;
      for (int i = 1; i < CHUNK; i++) begin
         c[i] = gp[i - 1];
      end
      return {gp[CHUNK-1], p ^ c};
   endfunction

   state_t             r_state;
   state_t             w_state_nx;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_sum;
   logic               r_carry;
   logic               r_zero;
   logic [KW-1:0]      r_k;
   int                 w_idx;
   logic [CHUNK:0]     w_core;

   // Current chunk through the core.
   always_comb begin
      w_idx  = int'(r_k) * CHUNK;
      w_core = bk_add(r_a[w_idx +: CHUNK], r_b[w_idx +: CHUNK], r_carry);
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE:  w_state_nx = in_valid ? S_RUN : S_IDLE;
         S_RUN:   w_state_nx = (r_k == K_LAST) ? S_DONE : S_RUN;
         S_DONE:  w_state_nx = out_ready ? S_IDLE : S_DONE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Operand capture and chunk-serial accumulation; subtraction is A + ~B + ~cin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_zero  <= 1'b0;
         r_k     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= in_a;
                  r_b     <= in_sub ? ~in_b : in_b;
                  r_carry <= in_sub ^ in_cin;
                  r_zero  <= 1'b1;
                  r_k     <= '0;
               end
            end
            S_RUN: begin
               r_sum[w_idx +: CHUNK] <= w_core[CHUNK-1:0];
               r_carry               <= w_core[CHUNK];
               r_zero                <= r_zero & (w_core[CHUNK-1:0] == '0);
               r_k                   <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign out_sum   = r_sum;
   assign out_cout  = r_carry;
   assign out_zero  = r_zero;

endmodule
